// File: rtl/shift_add_multiplier_8bit_if.sv
// Request/response bundle for the sequential shift-add multiplier.
// Valid/ready semantics: the master raises start with a/b stable; the request
// is accepted on the first rising edge where the slave is in IDLE (busy=0,
// done=0). The slave answers with a single-cycle done pulse, and product is
// valid from that pulse until the next completion or reset.
interface shift_add_multiplier_8bit_if #(
    parameter int WIDTH = 8
);
    logic                 start;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   product;
    logic [1:0]           state_dbg;  // FSM state for checkers (0 IDLE, 1 CALC, 2 DONE)

    modport master (
        output start, a, b,
        input  busy, done, product, state_dbg
    );

    modport slave (
        input  start, a, b,
        output busy, done, product, state_dbg
    );
endinterface

// File: rtl/shift_add_multiplier_8bit.sv
// Sequential unsigned WIDTH x WIDTH multiplier: one WIDTH-bit add with
// carry-out per clock, then a right shift of {C,A,Q}. WIDTH iterations per
// product, result registered with a single-cycle done pulse.
module shift_add_multiplier_8bit #(
    parameter int WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    shift_add_multiplier_8bit_if.slave    bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   m_q, m_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic               c_q, c_d;
    logic [CW-1:0]      count_q, count_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [2*WIDTH-1:0] product_q, product_d;

    // {C,A} after the conditional add; C is always clear entering an
    // iteration, so the carry-out of A+M lands in the top bit without loss.
    logic [WIDTH:0]     sum;

    // Conditional add of the multiplicand, selected by the multiplier LSB
    always_comb begin
        sum = {c_q, a_q};
        if (q_q[0]) begin
            sum = {c_q, a_q} + {1'b0, m_q};
        end
    end

    // Next-state and datapath updates; every output is registered
    always_comb begin
        state_d   = state_q;
        m_d       = m_q;
        a_d       = a_q;
        q_d       = q_q;
        c_d       = c_q;
        count_d   = count_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        product_d = product_q;

        case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                if (bus.start) begin
                    m_d     = bus.a;
                    q_d     = bus.b;
                    a_d     = '0;
                    c_d     = 1'b0;
                    count_d = CW'(WIDTH);
                    state_d = S_CALC;
                    busy_d  = 1'b1;
                end
            end

            S_CALC: begin
                // Shift {C,A,Q} right by one: carry enters A's MSB, A's LSB
                // enters Q's MSB, and C is left at zero.
                a_d     = sum[WIDTH:1];
                q_d     = {sum[0], q_q[WIDTH-1:1]};
                c_d     = 1'b0;
                count_d = count_q - CW'(1);
                if (count_q == CW'(1)) begin
                    state_d   = S_DONE;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    product_d = {sum[WIDTH:1], sum[0], q_q[WIDTH-1:1]};
                end
            end

            S_DONE: begin
                // One-cycle completion pulse; start is not looked at here
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end

            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            m_q       <= '0;
            a_q       <= '0;
            q_q       <= '0;
            c_q       <= 1'b0;
            count_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            m_q       <= m_d;
            a_q       <= a_d;
            q_q       <= q_d;
            c_q       <= c_d;
            count_q   <= count_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            product_q <= product_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.product   = product_q;
    assign bus.state_dbg = state_q;

endmodule
